// File: rtl/float_div_pkg.sv
//==============================================================================
// Module      : float_div_pkg
// Description : Shared types, constants and helpers for the iterative
//               floating-point divider (state encoding, exponent bias,
//               quotient width, canonical NaN fields).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package float_div_pkg;

  // Divider control states; IDLE encodes to zero so reset lands there.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    DIV  = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Canonical NaN: positive, quiet bit (fraction MSB) set, rest zero.
  localparam logic CANON_NAN_SIGN  = 1'b0;
  localparam logic CANON_NAN_QUIET = 1'b1;

  // IEEE exponent bias for an exponent field of exp_w bits.
  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quotient bits produced: hidden bit, fraction, trailing bits, plus one
  // guard position so an un-normalized (<1) quotient can be shifted up.
  function automatic int quot_width(input int frac_w, input int trail_w);
    return frac_w + trail_w + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/float_div_step.sv
//==============================================================================
// Module      : float_div_step
// Description : One combinational radix-2 restoring division iteration.
//               Produces the quotient bit and the next (shifted) remainder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module float_div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] div_in,
  output logic         q_bit,
  output logic [W-1:0] rem_out
);

  logic [W-1:0] diff;

  // Subtract the divisor when it fits, then shift the remainder up one place.
  always_comb begin
    q_bit   = (rem_in >= div_in);
    diff    = q_bit ? (rem_in - div_in) : rem_in;
    rem_out = diff << 1;
  end

endmodule

`default_nettype wire

// File: rtl/float_divide_iter.sv
//==============================================================================
// Module      : float_divide_iter
// Description : Iterative floating-point divider a / b. One quotient bit per
//               cycle, valid/ready on both sides, one operation in flight.
//               Emits an unrounded fraction, trailing bits and a sticky bit
//               for a shared downstream rounder.
//               Build option FLOAT_DIV_DENORMAL_EN: when defined, denormal
//               inputs are normalized and underflowing results become
//               denormals; otherwise denormals are treated as zero and
//               underflow flushes to signed zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module float_divide_iter
  import float_div_pkg::*;
#(
  parameter int EXP           = 8,
  parameter int FRAC          = 23,
  parameter int TRAILING_BITS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     a_sign,
  input  logic [EXP-1:0]           a_exp,
  input  logic [FRAC-1:0]          a_frac,
  input  logic                     b_sign,
  input  logic [EXP-1:0]           b_exp,
  input  logic [FRAC-1:0]          b_frac,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP-1:0]           out_exp,
  output logic [FRAC-1:0]          out_frac,
  output logic [TRAILING_BITS-1:0] trailing_bits_out,
  output logic                     sticky_bit_out,
  output logic                     is_nan_out,
  output logic                     is_div_by_zero_out
);

  localparam int Q   = quot_width(FRAC, TRAILING_BITS);
  localparam int M   = FRAC + 1;                    // mantissa incl. hidden bit
  localparam int RW  = FRAC + 2;                    // remainder stays below 2*mb
  localparam int EW  = EXP + 2;                     // signed internal exponent
  localparam int CW  = $clog2(Q + 1);
  localparam int LOW = Q - 1 - FRAC - TRAILING_BITS; // bits below the trailing bits

  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_BIAS = EW'(exp_bias(EXP));
  localparam logic signed [EW-1:0] E_OVF  = EW'((1 << EXP) - 1);
  localparam logic [CW-1:0]        LAST_ITER = CW'(Q - 1);
  localparam logic [FRAC-1:0]      NAN_FRAC  = {CANON_NAN_QUIET, {(FRAC-1){1'b0}}};

  // Control and datapath state
  div_state_e               state_q, state_d;
  logic                     sign_q, sign_d;
  logic [M-1:0]             ma_q, ma_d;
  logic [M-1:0]             mb_q, mb_d;
  logic signed [EW-1:0]     ea_q, ea_d;
  logic signed [EW-1:0]     eb_q, eb_d;
  logic signed [EW-1:0]     e_q, e_d;
  logic [RW-1:0]            rem_q, rem_d;
  logic [Q-1:0]             quot_q, quot_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sticky_q, sticky_d;

  // Registered result fields, held stable through DONE
  logic                     o_sign_q, o_sign_d;
  logic [EXP-1:0]           o_exp_q, o_exp_d;
  logic [FRAC-1:0]          o_frac_q, o_frac_d;
  logic [TRAILING_BITS-1:0] o_trail_q, o_trail_d;
  logic                     o_sticky_q, o_sticky_d;
  logic                     o_nan_q, o_nan_d;
  logic                     o_dbz_q, o_dbz_d;

  // Operand classification
  logic a_ones, a_zexp, a_zfrac, a_nan, a_inf, a_zero, a_fnz;
  logic b_ones, b_zexp, b_zfrac, b_nan, b_inf, b_zero;
  logic sp_nan, sp_inf, sp_zero;

  assign a_ones  = &a_exp;
  assign a_zexp  = ~|a_exp;
  assign a_zfrac = ~|a_frac;
  assign b_ones  = &b_exp;
  assign b_zexp  = ~|b_exp;
  assign b_zfrac = ~|b_frac;

  assign a_nan = a_ones & ~a_zfrac;
  assign a_inf = a_ones &  a_zfrac;
  assign b_nan = b_ones & ~b_zfrac;
  assign b_inf = b_ones &  b_zfrac;

`ifdef FLOAT_DIV_DENORMAL_EN
  assign a_zero = a_zexp & a_zfrac;
  assign b_zero = b_zexp & b_zfrac;
`else
  // Denormals collapse to zero, so only the exponent field matters.
  assign a_zero = a_zexp;
  assign b_zero = b_zexp;
`endif

  assign a_fnz   = ~a_ones & ~a_zero;
  assign sp_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign sp_inf  = a_inf | (b_zero & a_fnz);
  assign sp_zero = a_zero | b_inf;

  // Restoring iteration datapath
  logic          step_q;
  logic [RW-1:0] step_rem;
  logic [Q-1:0]  quot_shift;

  float_div_step #(
    .W (RW)
  ) u_step (
    .rem_in  (rem_q),
    .div_in  (RW'(mb_q)),
    .q_bit   (step_q),
    .rem_out (step_rem)
  );

  assign quot_shift = {quot_q[Q-2:0], step_q};

  // Next-state and datapath updates for the divider sequence.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    e_d        = e_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    o_sign_d   = o_sign_q;
    o_exp_d    = o_exp_q;
    o_frac_d   = o_frac_q;
    o_trail_d  = o_trail_q;
    o_sticky_d = o_sticky_q;
    o_nan_d    = o_nan_q;
    o_dbz_d    = o_dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = a_sign ^ b_sign;
          // Denormals carry hidden bit 0 and an effective exponent of 1.
          ma_d       = {~a_zexp, a_frac};
          mb_d       = {~b_zexp, b_frac};
          ea_d       = a_zexp ? E_ONE : EW'(a_exp);
          eb_d       = b_zexp ? E_ONE : EW'(b_exp);
          sticky_d   = 1'b0;
          o_trail_d  = '0;
          o_sticky_d = 1'b0;
          o_nan_d    = 1'b0;
          o_dbz_d    = 1'b0;
          if (sp_nan) begin
            o_sign_d = CANON_NAN_SIGN;
            o_exp_d  = '1;
            o_frac_d = NAN_FRAC;
            o_nan_d  = 1'b1;
            state_d  = DONE;
          end else if (sp_inf) begin
            o_sign_d = a_sign ^ b_sign;
            o_exp_d  = '1;
            o_frac_d = '0;
            o_dbz_d  = b_zero & a_fnz;
            state_d  = DONE;
          end else if (sp_zero) begin
            o_sign_d = a_sign ^ b_sign;
            o_exp_d  = '0;
            o_frac_d = '0;
            state_d  = DONE;
          end else begin
            state_d  = NORM;
          end
        end
      end

      NORM: begin
`ifdef FLOAT_DIV_DENORMAL_EN
        if (ma_q[FRAC] && mb_q[FRAC]) begin
          e_d     = ea_q - eb_q + E_BIAS;
          rem_d   = RW'(ma_q);
          quot_d  = '0;
          cnt_d   = '0;
          state_d = DIV;
        end else begin
          if (!ma_q[FRAC]) begin
            ma_d = ma_q << 1;
            ea_d = ea_q - E_ONE;
          end
          if (!mb_q[FRAC]) begin
            mb_d = mb_q << 1;
            eb_d = eb_q - E_ONE;
          end
        end
`else
        e_d     = ea_q - eb_q + E_BIAS;
        rem_d   = RW'(ma_q);
        quot_d  = '0;
        cnt_d   = '0;
        state_d = DIV;
`endif
      end

      DIV: begin
        rem_d  = step_rem;
        cnt_d  = cnt_q + 1'b1;
        quot_d = quot_shift;
        if (cnt_q == LAST_ITER) begin
          state_d = POST;
          // Quotient in [0.5,1): bring the leading one up to the hidden position.
          if (!quot_shift[Q-1]) begin
            quot_d = quot_shift << 1;
            e_d    = e_q - E_ONE;
          end
        end
      end

      POST: begin
        if (e_q >= E_OVF) begin
          o_sign_d   = sign_q;
          o_exp_d    = '1;
          o_frac_d   = '0;
          o_trail_d  = '0;
          o_sticky_d = 1'b0;
          state_d    = DONE;
        end else if (e_q < E_ONE) begin
`ifdef FLOAT_DIV_DENORMAL_EN
          // Denormalize one position per cycle, keeping lost bits in sticky.
          quot_d   = quot_q >> 1;
          sticky_d = sticky_q | quot_q[0];
          e_d      = e_q + E_ONE;
`else
          o_sign_d   = sign_q;
          o_exp_d    = '0;
          o_frac_d   = '0;
          o_trail_d  = '0;
          o_sticky_d = 1'b0;
          state_d    = DONE;
`endif
        end else begin
          o_sign_d   = sign_q;
          o_exp_d    = quot_q[Q-1] ? e_q[EXP-1:0] : '0;
          o_frac_d   = quot_q[Q-2 -: FRAC];
          o_trail_d  = quot_q[Q-2-FRAC -: TRAILING_BITS];
          o_sticky_d = sticky_q | (|quot_q[LOW-1:0]) | (|rem_q);
          state_d    = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      e_q        <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      o_sign_q   <= 1'b0;
      o_exp_q    <= '0;
      o_frac_q   <= '0;
      o_trail_q  <= '0;
      o_sticky_q <= 1'b0;
      o_nan_q    <= 1'b0;
      o_dbz_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      e_q        <= e_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      o_sign_q   <= o_sign_d;
      o_exp_q    <= o_exp_d;
      o_frac_q   <= o_frac_d;
      o_trail_q  <= o_trail_d;
      o_sticky_q <= o_sticky_d;
      o_nan_q    <= o_nan_d;
      o_dbz_q    <= o_dbz_d;
    end
  end

  assign in_ready           = (state_q == IDLE);
  assign out_valid          = (state_q == DONE);
  assign out_sign           = o_sign_q;
  assign out_exp            = o_exp_q;
  assign out_frac           = o_frac_q;
  assign trailing_bits_out  = o_trail_q;
  assign sticky_bit_out     = o_sticky_q;
  assign is_nan_out         = o_nan_q;
  assign is_div_by_zero_out = o_dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_float_divide_iter.sv
//==============================================================================
// Module      : tb_float_divide_iter
// Description : Self-checking bench for float_divide_iter (single precision).
//               Expected results are queued at stimulus time and compared
//               when the divider presents its result. Honours
//               FLOAT_DIV_DENORMAL_EN for the denormal/underflow vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_float_divide_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        a_sign = 1'b0;
  logic [7:0]  a_exp = '0;
  logic [22:0] a_frac = '0;
  logic        b_sign = 1'b0;
  logic [7:0]  b_exp = '0;
  logic [22:0] b_frac = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic [1:0]  trailing_bits_out;
  logic        sticky_bit_out;
  logic        is_nan_out;
  logic        is_div_by_zero_out;

  float_divide_iter #(
    .EXP           (8),
    .FRAC          (23),
    .TRAILING_BITS (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .a_sign             (a_sign),
    .a_exp              (a_exp),
    .a_frac             (a_frac),
    .b_sign             (b_sign),
    .b_exp              (b_exp),
    .b_frac             (b_frac),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_sign           (out_sign),
    .out_exp            (out_exp),
    .out_frac           (out_frac),
    .trailing_bits_out  (trailing_bits_out),
    .sticky_bit_out     (sticky_bit_out),
    .is_nan_out         (is_nan_out),
    .is_div_by_zero_out (is_div_by_zero_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sgn;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [1:0]  tr;
    logic        st;
    logic        nan;
    logic        dbz;
    int          lat;   // edges from accept to out_valid; -1 = not checked
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [7:0] ex, input logic [22:0] fr,
                              input logic [1:0] tr, input logic st, input logic nan,
                              input logic dbz, input int lat);
    exp_t r;
    r.sgn = s; r.ex = ex; r.fr = fr; r.tr = tr; r.st = st; r.nan = nan; r.dbz = dbz; r.lat = lat;
    return r;
  endfunction

  function automatic vec_t mv(input logic [31:0] a, input logic [31:0] b, input exp_t e, input int hold);
    vec_t v;
    v.a = a; v.b = b; v.e = e; v.hold = hold;
    return v;
  endfunction

  // Entered at a negedge; leaves at the negedge right after the output handshake.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int hold);
    exp_t        x;
    int          edges;
    int          waitn;
    logic        bad;
    logic [30:0] first_fields;
    waitn = 0;
    while (!in_ready && waitn < 400) begin
      @(negedge clock);
      waitn++;
    end
    check_val($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_sign = a[31]; a_exp = a[30:23]; a_frac = a[22:0];
    b_sign = b[31]; b_exp = b[30:23]; b_frac = b[22:0];
    sb.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 400) begin
      @(negedge clock);
      edges++;
    end
    check_val($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
    if (e.lat >= 0)
      check_val($sformatf("v%0d_latency", idx), 32'(edges), 32'(e.lat));
    first_fields = {out_exp, out_frac};
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (in_ready || !out_valid || ({out_exp, out_frac} != first_fields)) bad = 1'b1;
    end
    if (hold > 0)
      check_val($sformatf("v%0d_hold_stable", idx), 32'(bad), 32'd0);
    x = sb.pop_front();
    check_val($sformatf("v%0d_sign", idx),   32'(out_sign), 32'(x.sgn));
    check_val($sformatf("v%0d_exp", idx),    32'(out_exp), 32'(x.ex));
    check_val($sformatf("v%0d_frac", idx),   32'(out_frac), 32'(x.fr));
    check_val($sformatf("v%0d_trail", idx),  32'(trailing_bits_out), 32'(x.tr));
    check_val($sformatf("v%0d_sticky", idx), 32'(sticky_bit_out), 32'(x.st));
    check_val($sformatf("v%0d_nan", idx),    32'(is_nan_out), 32'(x.nan));
    check_val($sformatf("v%0d_dbz", idx),    32'(is_div_by_zero_out), 32'(x.dbz));
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_valid;

    // Normal operands (Q+2 = 29 edges to out_valid)
    vecs.push_back(mv(32'h40C00000, 32'h40000000, mk(1'b0, 8'h80, 23'h400000, 2'b00, 1'b0, 1'b0, 1'b0, 29), 10));
    vecs.push_back(mv(32'h3F800000, 32'h40400000, mk(1'b0, 8'h7D, 23'h2AAAAA, 2'b10, 1'b1, 1'b0, 1'b0, 29), 0));
    vecs.push_back(mv(32'hC0400000, 32'h40000000, mk(1'b1, 8'h7F, 23'h400000, 2'b00, 1'b0, 1'b0, 1'b0, 29), 0));
    vecs.push_back(mv(32'h3F800000, 32'h3FC00000, mk(1'b0, 8'h7E, 23'h2AAAAA, 2'b10, 1'b1, 1'b0, 1'b0, 29), 0));
    vecs.push_back(mv(32'hBF800000, 32'hC0400000, mk(1'b0, 8'h7D, 23'h2AAAAA, 2'b10, 1'b1, 1'b0, 1'b0, 29), 0));
    vecs.push_back(mv(32'h7F7FFFFF, 32'h3F800000, mk(1'b0, 8'hFE, 23'h7FFFFF, 2'b00, 1'b0, 1'b0, 1'b0, 29), 0));
    // Exponent overflow from normal operands
    vecs.push_back(mv(32'h7F000000, 32'h3E800000, mk(1'b0, 8'hFF, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 29), 0));
    // Special operands: result visible in the cycle right after accept
    vecs.push_back(mv(32'h3F800000, 32'h00000000, mk(1'b0, 8'hFF, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b1, 0), 3));
    vecs.push_back(mv(32'h00000000, 32'h00000000, mk(1'b0, 8'hFF, 23'h400000, 2'b00, 1'b0, 1'b1, 1'b0, 0), 0));
    vecs.push_back(mv(32'h7F800000, 32'hFF800000, mk(1'b0, 8'hFF, 23'h400000, 2'b00, 1'b0, 1'b1, 1'b0, 0), 0));
    vecs.push_back(mv(32'hFFC00000, 32'h3F800000, mk(1'b0, 8'hFF, 23'h400000, 2'b00, 1'b0, 1'b1, 1'b0, 0), 0));
    vecs.push_back(mv(32'h3F800000, 32'hFF800000, mk(1'b1, 8'h00, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 0), 0));
    vecs.push_back(mv(32'h80000000, 32'h40A00000, mk(1'b1, 8'h00, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 0), 0));
    vecs.push_back(mv(32'hFF800000, 32'h40000000, mk(1'b1, 8'hFF, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 0), 0));
`ifdef FLOAT_DIV_DENORMAL_EN
    // Underflow to denormal (one POST shift), denormal input (one NORM shift)
    vecs.push_back(mv(32'h00800000, 32'h40000000, mk(1'b0, 8'h00, 23'h400000, 2'b00, 1'b0, 1'b0, 1'b0, 30), 0));
    vecs.push_back(mv(32'h00400000, 32'h3F800000, mk(1'b0, 8'h00, 23'h400000, 2'b00, 1'b0, 1'b0, 1'b0, 31), 0));
    vecs.push_back(mv(32'h00400000, 32'h00000000, mk(1'b0, 8'hFF, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b1, 0), 0));
`else
    // Underflow flushes to zero; denormal inputs behave as zero
    vecs.push_back(mv(32'h00800000, 32'h40000000, mk(1'b0, 8'h00, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 29), 0));
    vecs.push_back(mv(32'h00400000, 32'h3F800000, mk(1'b0, 8'h00, 23'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 0), 0));
    vecs.push_back(mv(32'h00400000, 32'h00000000, mk(1'b0, 8'hFF, 23'h400000, 2'b00, 1'b0, 1'b1, 1'b0, 0), 0));
`endif

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_val("reset_in_ready", 32'(in_ready), 32'd1);
    check_val("reset_out_exp", 32'(out_exp), 32'd0);
    check_val("reset_out_frac", 32'(out_frac), 32'd0);
    check_val("reset_flags", 32'({is_nan_out, is_div_by_zero_out, sticky_bit_out}), 32'd0);

    foreach (vecs[i]) run_op(i, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].hold);

    // Abort mid-division: reset must drop the operation without a result
    in_valid = 1'b1;
    a_sign = 1'b0; a_exp = 8'h81; a_frac = 23'h400000;
    b_sign = 1'b0; b_exp = 8'h80; b_frac = 23'h000000;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    check_val("mid_div_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("abort_out_valid", 32'(out_valid), 32'd0);
    check_val("abort_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) seen_valid = 1'b1;
    end
    check_val("abort_no_result", 32'(seen_valid), 32'd0);

    // Divider is usable again after the abort
    run_op(99, 32'h40C00000, 32'h40000000,
           mk(1'b0, 8'h80, 23'h400000, 2'b00, 1'b0, 1'b0, 1'b0, 29), 0);

    check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/float_divide_iter.md
Name: float_divide_iter

Overview:
- Iterative IEEE-style floating-point divider producing a / b.
- Emits an unrounded fraction plus trailing bits and a sticky bit, the same result format as the pipelined multiplier, so both feed the same downstream rounder.
- Radix-2 restoring mantissa division, one quotient bit per cycle.
- Valid/ready handshake on input and output; one operation in flight.

Parameters:
- EXP, 8, exponent field width (in and out).
- FRAC, 23, fraction field width (in and out).
- TRAILING_BITS, 2, extra quotient bits below the fraction; must be 1..FRAC-1.

Ports:
- clock input 1 clock
- reset input 1 reset
- in_valid input 1 operands valid
- in_ready output 1 divider idle and able to accept
- a_sign / a_exp / a_frac input 1 / EXP / FRAC dividend fields
- b_sign / b_exp / b_frac input 1 / EXP / FRAC divisor fields
- out_valid output 1 result valid
- out_ready input 1 consumer accepts result
- out_sign / out_exp / out_frac output 1 / EXP / FRAC result fields
- trailing_bits_out output TRAILING_BITS quotient bits below the fraction
- sticky_bit_out output 1 OR of all lower bits and the nonzero final remainder
- is_nan_out output 1 result is NaN
- is_div_by_zero_out output 1 finite nonzero a divided by zero

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset: state IDLE; all outputs and internal registers 0; in_ready = 1 in the first cycle after reset. Reset mid-operation aborts; no result is emitted.
- in_ready = (state == IDLE), combinational. An accept happens at an edge with in_valid && in_ready.
- Quotient width Q = FRAC + TRAILING_BITS + 2. Internal exponent is signed, EXP+2 bits.
- State IDLE, on accept: register sign = a_sign ^ b_sign, then classify:
  - NaN if either input is NaN, or 0/0, or inf/inf. Output exp all-ones, frac = {1, 0...}, sign 0, is_nan_out = 1.
  - Inf if a is inf, or b is zero with a finite nonzero. In the zero-divisor case is_div_by_zero_out = 1.
  - Zero if a is zero or b is inf.
  - Any special case goes to DONE. Its trailing and sticky outputs are 0.
  - Otherwise go to NORM. Mantissa m = {hidden, frac}; a denormal uses hidden = 0 and exponent field value 1.
- State NORM:
  - Each cycle, every mantissa whose bit FRAC is 0 shifts left 1 and its exponent decrements.
  - When both mantissas are normalized, e = ea - eb + bias, then go to DIV.
  - NORM always occupies at least 1 cycle.
- State DIV:
  - Remainder starts as ma.
  - Each cycle: q = (r >= mb); r = (q ? r - mb : r) << 1; q shifts into the quotient LSB.
  - After Q cycles go to POST. If quotient MSB is 0, shift the quotient left 1 and decrement e.
- State POST:
  - If e >= 2^EXP - 1: result is inf.
  - Else if e <= 0: shift the quotient right 1 per cycle, OR the shifted-out bits into sticky, and increment e until e = 1. The exponent field is then 0. After Q shifts the mantissa is 0.
  - Then go to DONE.
- Output field mapping: out_frac = quotient[Q-2 -: FRAC]; trailing = next TRAILING_BITS; sticky = OR(remaining bits) | (r != 0).
- State DONE: out_valid = 1; outputs are held stable until out_ready, then return to IDLE. A new accept is possible the cycle after the handshake.
- Latency, normal operands with normal result: out_valid rises Q+2 cycles after the accept edge (29 for defaults). Special operands: 1 cycle after accept.
- Output sign: product-style sign XOR for zero and inf results; NaN is always positive.

Optional Feature:
- Macro: FLOAT_DIV_DENORMAL_EN.
- Defined: denormal inputs are normalized in NORM, and underflowing results become denormals via the POST shift.
- Undefined:
  - Denormal inputs are treated as zero, sign kept; 0/denormal gives NaN.
  - Results with e <= 0 flush to signed zero with trailing and sticky 0.
  - NORM lasts exactly 1 cycle, and POST has no shift loop.

Decomposition:
- Shared package float_div_pkg holds:
  - state enum (IDLE, NORM, DIV, POST, DONE);
  - exp bias function;
  - quotient width function;
  - canonical NaN constant.
- One sub-module, float_div_step: combinational single restoring iteration (r, mb → q bit, next r).

Test Plan:
- 6.0 / 2.0: 0x40C00000 / 0x40000000 → exp 0x80, frac 0x400000, trailing 0, sticky 0; out_valid exactly 29 cycles after accept.
- 1.0 / 3.0: 0x3F800000 / 0x40400000 → exp 0x7D, frac 0x2AAAAA, trailing 2'b10, sticky 1.
- 1.0 / 0.0 → 0x7F800000 with is_div_by_zero_out = 1, 1 cycle after accept. 0.0 / 0.0 → exp 0xFF, frac 0x400000, is_nan_out = 1.
- 0x7F000000 / 0x3E800000 (2^127 / 0.25) → inf 0x7F800000, is_div_by_zero_out = 0.
- 0x00800000 / 0x40000000 → with macro: exp 0, frac 0x400000, sticky 0. Without macro: all fields 0.
- Backpressure and reset:
  - Hold out_ready = 0 for 10 cycles → outputs stable, in_ready = 0.
  - Release → next operand accepted the following cycle.
  - Assert reset during DIV → out_valid = 0, in_ready = 1 after reset.
